// File: rtl/minmax_reduce_pkg.sv
// Shared types and floating-point helpers for the min/max reduction tree.
// Helpers take the field widths as arguments so one package serves any format
// up to FP_MAX_W bits; callers truncate results to their own DATA_W.
package reduce_pkg;

  typedef enum logic {
    MODE_MIN = 1'b0,
    MODE_MAX = 1'b1
  } mode_e;

  localparam int unsigned FP_MAX_W = 64;

  typedef logic [FP_MAX_W-1:0] fp_word_t;

  // Low w bits set (w < FP_MAX_W).
  function automatic fp_word_t fp_mask(input int unsigned w);
    return (fp_word_t'(1) << w) - fp_word_t'(1);
  endfunction

  // Maps a float onto an unsigned key whose natural order is the total order
  // -inf < ... < -0 < +0 < ... < +inf. Negative values are fully inverted so
  // larger magnitudes sort lower; positives get the sign bit set so they sit
  // above every negative.
  function automatic fp_word_t fp_key(input fp_word_t x,
                                      input int unsigned exp_w,
                                      input int unsigned man_w);
    fp_word_t msb;
    fp_word_t mask;
    msb  = fp_word_t'(1) << (exp_w + man_w);
    mask = fp_mask(1 + exp_w + man_w);
    if ((x & msb) != '0) begin
      return ~x & mask;
    end
    return (x ^ msb) & mask;
  endfunction

  // Exponent all ones with a non-zero mantissa.
  function automatic logic is_nan(input fp_word_t x,
                                  input int unsigned exp_w,
                                  input int unsigned man_w);
    fp_word_t exp_f;
    fp_word_t man_f;
    exp_f = (x >> man_w) & fp_mask(exp_w);
    man_f = x & fp_mask(man_w);
    return (exp_f == fp_mask(exp_w)) && (man_f != '0);
  endfunction

  // +inf: sign 0, exponent all ones, mantissa 0.
  function automatic fp_word_t pos_inf(input int unsigned exp_w,
                                       input int unsigned man_w);
    return fp_mask(exp_w) << man_w;
  endfunction

  // -inf: +inf with the sign bit set.
  function automatic fp_word_t neg_inf(input int unsigned exp_w,
                                       input int unsigned man_w);
    return pos_inf(exp_w, man_w) | (fp_word_t'(1) << (exp_w + man_w));
  endfunction

endpackage

// File: rtl/minmax_node.sv
// One compare+select node of the reduction tree plus its output register.
// Input a is always the lower-numbered channel group, so an equal-key tie
// keeps a. With REDUCE_ARGIDX_EN defined the winning index is carried too.
module minmax_node
  import reduce_pkg::*;
#(
  parameter  int EXP_W  = 5,
  parameter  int MAN_W  = 10,
  parameter  int IDX_W  = 2,
  localparam int DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              en,
  input  mode_e             mode,
  input  logic              a_elig,
  input  logic [DATA_W-1:0] a_val,
`ifdef REDUCE_ARGIDX_EN
  input  logic [IDX_W-1:0]  a_idx,
`endif
  input  logic              b_elig,
  input  logic [DATA_W-1:0] b_val,
`ifdef REDUCE_ARGIDX_EN
  input  logic [IDX_W-1:0]  b_idx,
  output logic [IDX_W-1:0]  q_idx,
`endif
  output logic              q_elig,
  output logic [DATA_W-1:0] q_val
);

  logic [DATA_W-1:0] a_key;
  logic [DATA_W-1:0] b_key;
  logic              take_b;

  // Decide whether the upper input replaces the lower one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    take_b = 1'b0;
    a_key  = DATA_W'(fp_key(fp_word_t'(a_val), EXP_W, MAN_W));
    b_key  = DATA_W'(fp_key(fp_word_t'(b_val), EXP_W, MAN_W));
    if (b_elig) begin
      if (!a_elig) begin
        take_b = 1'b1;
      end else if (mode == MODE_MAX) begin
        take_b = (b_key > a_key);
      end else begin
        take_b = (b_key < a_key);
      end
    end
  end

  // Stage register: loads the winner whenever the tree advances.
  always_ff @(posedge aclk or posedge areset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (areset) begin
      q_elig <= 1'b0;
      q_val  <= '0;
`ifdef REDUCE_ARGIDX_EN
      q_idx  <= '0;
`endif
    end else if (en) begin
      q_elig <= a_elig | b_elig;
      q_val  <= take_b ? b_val : a_val;
`ifdef REDUCE_ARGIDX_EN
      q_idx  <= take_b ? b_idx : a_idx;
`endif
    end
  end

endmodule

// File: rtl/minmax_reduce.sv
// Streaming N-channel floating-point min/max reduction with select mask.
// Optional feature: define REDUCE_ARGIDX_EN to carry the winning channel
// index through the tree and drive the oidx port.
// The tree is a heap: node i combines nodes 2i and 2i+1, leaves P..2P-1 are
// the (padded) input lanes, node 1 is the root. Each node is registered, so a
// beat reaches the root after L = $clog2(N) advancing edges.
module minmax_reduce
  import reduce_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int EXP_W  = 5,
  parameter  int MAN_W  = 10,
  localparam int DATA_W = 1 + EXP_W + MAN_W,
  localparam int IDX_W  = $clog2(N)
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [N-1:0]        isel,
  input  logic                imode,
  input  logic [N*DATA_W-1:0] idata,
  input  logic                ivalid,
  output logic                iready,
  input  logic                istart,
  input  logic                ilast,
  output logic [DATA_W-1:0]   odata,
`ifdef REDUCE_ARGIDX_EN
  output logic [IDX_W-1:0]    oidx,
`endif
  output logic                oempty,
  output logic                ovalid,
  input  logic                oready,
  output logic                ostart,
  output logic                olast
);

  localparam int L = $clog2(N);
  localparam int P = 1 << L;

  localparam logic [DATA_W-1:0] POS_INF = DATA_W'(pos_inf(EXP_W, MAN_W));
  localparam logic [DATA_W-1:0] NEG_INF = DATA_W'(neg_inf(EXP_W, MAN_W));

  logic en;

  // Per-level control: index 0 is the live input, index L is the root stage.
  logic [L:1] valid_q;
  logic [L:1] mode_q;
  logic [L:1] start_q;
  logic [L:1] last_q;
  logic [L:0] valid_pipe;
  logic [L:0] mode_pipe;
  logic [L:0] start_pipe;
  logic [L:0] last_pipe;

  // Heap-ordered tree signals.
  logic              t_elig [1:2*P-1];
  logic [DATA_W-1:0] t_val  [1:2*P-1];
`ifdef REDUCE_ARGIDX_EN
  logic [IDX_W-1:0]  t_idx  [1:2*P-1];
`endif

  // Single global enable: the whole pipe moves or the whole pipe holds.
  // iready never looks at ivalid, so upstream can wait on it safely.
  assign ovalid = valid_pipe[L];
  assign en     = ~ovalid | oready;
  assign iready = en;

  // Framing is qualified with ivalid so bubbles never carry a stray start/last.
  assign valid_pipe = {valid_q, ivalid};
  assign mode_pipe  = {mode_q,  imode};
  assign start_pipe = {start_q, istart & ivalid};
  assign last_pipe  = {last_q,  ilast  & ivalid};

  // Sideband shift register moving in lockstep with the tree stages.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      valid_q <= '0;
      mode_q  <= '0;
      start_q <= '0;
      last_q  <= '0;
    end else if (en) begin
      valid_q <= valid_pipe[L-1:0];
      mode_q  <= mode_pipe[L-1:0];
      start_q <= start_pipe[L-1:0];
      last_q  <= last_pipe[L-1:0];
    end
  end

  // Leaf lanes: real channels are eligible when selected and not NaN;
  // pad lanes beyond N are tied off as ineligible.
  for (genvar k = 0; k < P; k++) begin : g_lane
    if (k < N) begin : g_real
      assign t_val[P+k]  = idata[k*DATA_W +: DATA_W];
      assign t_elig[P+k] = isel[k] &
                           ~is_nan(fp_word_t'(idata[k*DATA_W +: DATA_W]), EXP_W, MAN_W);
`ifdef REDUCE_ARGIDX_EN
      assign t_idx[P+k]  = IDX_W'(k);
`endif
    end else begin : g_pad
      assign t_val[P+k]  = '0;
      assign t_elig[P+k] = 1'b0;
`ifdef REDUCE_ARGIDX_EN
      assign t_idx[P+k]  = '0;
`endif
    end
  end

  // Internal nodes; a node at depth D consumes the beat held at level L-1-D.
  for (genvar i = 1; i < P; i++) begin : g_node
    localparam int D = $clog2(i + 1) - 1;
    minmax_node #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W),
      .IDX_W (IDX_W)
    ) u_node (
      .aclk   (aclk),
      .areset (areset),
      .en     (en),
      .mode   (mode_e'(mode_pipe[L-1-D])),
      .a_elig (t_elig[2*i]),
      .a_val  (t_val[2*i]),
`ifdef REDUCE_ARGIDX_EN
      .a_idx  (t_idx[2*i]),
`endif
      .b_elig (t_elig[2*i+1]),
      .b_val  (t_val[2*i+1]),
`ifdef REDUCE_ARGIDX_EN
      .b_idx  (t_idx[2*i+1]),
      .q_idx  (t_idx[i]),
`endif
      .q_elig (t_elig[i]),
      .q_val  (t_val[i])
    );
  end

  // An empty beat reports the identity of the operation: +inf for min,
  // -inf for max, index 0. Gating with ovalid keeps idle outputs at reset values.
  assign oempty = ovalid & ~t_elig[1];
  assign odata  = oempty ? (mode_pipe[L] ? NEG_INF : POS_INF) : t_val[1];
`ifdef REDUCE_ARGIDX_EN
  assign oidx   = oempty ? '0 : t_idx[1];
`endif
  assign ostart = start_pipe[L];
  assign olast  = last_pipe[L];

endmodule

// File: tb/tb_minmax_reduce.sv
// Self-checking bench for minmax_reduce (N=4, binary16). Expected results are
// computed by a sign/magnitude reference model when a beat is accepted, queued,
// and compared against the DUT output for as long as that beat is presented.
module tb_minmax_reduce;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  logic          aclk = 1'b0;
  logic          areset;
  logic [N-1:0]  isel;
  logic          imode;
  logic [N*DW-1:0] idata;
  logic          ivalid;
  logic          iready;
  logic          istart;
  logic          ilast;
  logic [DW-1:0] odata;
  logic [IW-1:0] oidx;
  logic          oempty;
  logic          ovalid;
  logic          oready;
  logic          ostart;
  logic          olast;

  always #5 aclk = ~aclk;

  minmax_reduce #(.N(N), .EXP_W(5), .MAN_W(10)) dut (
    .aclk   (aclk),
    .areset (areset),
    .isel   (isel),
    .imode  (imode),
    .idata  (idata),
    .ivalid (ivalid),
    .iready (iready),
    .istart (istart),
    .ilast  (ilast),
    .odata  (odata),
`ifdef REDUCE_ARGIDX_EN
    .oidx   (oidx),
`endif
    .oempty (oempty),
    .ovalid (ovalid),
    .oready (oready),
    .ostart (ostart),
    .olast  (olast)
  );

`ifndef REDUCE_ARGIDX_EN
  assign oidx = '0;
`endif

  typedef struct {
    logic [15:0] data;
    logic [1:0]  idx;
    logic        empty;
    logic        start;
    logic        last;
    int          acc_cyc;
    bit          seen;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;
  bit   chk_lat = 1'b1;

  logic [15:0] pool [10] = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00, 16'h7C00,
                             16'hFC00, 16'h7E00, 16'h4200, 16'h0001, 16'h8001};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit nan16(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
  endfunction

  // a strictly before b in the total order (-0 before +0).
  function automatic bit less16(input logic [15:0] a, input logic [15:0] b);
    if (a[15] != b[15]) return a[15];
    if (!a[15]) return a[14:0] < b[14:0];
    return a[14:0] > b[14:0];
  endfunction

  function automatic exp_t model(input logic [3:0] sel, input bit mode, input logic [63:0] data);
    exp_t e;
    int best;
    logic [15:0] x;
    logic [15:0] bx;
    best = -1;
    bx = '0;
    for (int k = 0; k < N; k++) begin
      x = data[k*16 +: 16];
      if (sel[k] && !nan16(x)) begin
        if (best < 0 || (mode ? less16(bx, x) : less16(x, bx))) begin
          best = k;
          bx = x;
        end
      end
    end
    e.empty = (best < 0);
    e.data  = e.empty ? (mode ? 16'hFC00 : 16'h7C00) : bx;
    e.idx   = e.empty ? 2'd0 : 2'(best);
    e.start = 1'b0;
    e.last  = 1'b0;
    e.acc_cyc = 0;
    e.seen  = 1'b0;
    return e;
  endfunction

  // Compares the presented output against the oldest outstanding beat.
  task automatic monitor();
    if (ovalid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_ovalid", 32'd1, 32'd0);
      end else begin
        check("odata",  odata,  sb[0].data);
`ifdef REDUCE_ARGIDX_EN
        check("oidx",   oidx,   sb[0].idx);
`endif
        check("oempty", oempty, sb[0].empty);
        check("ostart", ostart, sb[0].start);
        check("olast",  olast,  sb[0].last);
        if (chk_lat && !sb[0].seen) check("latency", cyc - sb[0].acc_cyc, 32'd2);
        sb[0].seen = 1'b1;
        if (oready) void'(sb.pop_front());
      end
    end
  endtask

  // One cycle: drive at the falling edge, sample 1 time unit later.
  task automatic step(input bit v, input logic [3:0] sel, input bit mode,
                      input logic [63:0] data, input bit st, input bit la,
                      input bit ordy, output bit acc);
    exp_t e;
    ivalid = v; isel = sel; imode = mode; idata = data;
    istart = st; ilast = la; oready = ordy;
    #1;
    monitor();
    acc = v && (iready === 1'b1);
    if (acc) begin
      e = model(sel, mode, data);
      e.start = st;
      e.last = la;
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge aclk);
    cyc++;
    @(negedge aclk);
  endtask

  task automatic send(input logic [3:0] sel, input bit mode, input logic [63:0] data,
                      input bit st, input bit la, input bit rnd);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      step(1'b1, sel, mode, data, st, la, rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      guard++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input bit rnd);
    bit acc;
    step(1'b0, 4'h0, 1'b0, 64'h0, 1'b0, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() > 0 || ovalid === 1'b1) && guard < 100) begin
      idle(1'b0);
      guard++;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  function automatic logic [63:0] rand_data();
    logic [63:0] d;
    for (int k = 0; k < N; k++) d[k*16 +: 16] = pool[$urandom_range(0, 9)];
    return d;
  endfunction

  localparam logic [63:0] D1   = {16'h4200, 16'hBC00, 16'h4000, 16'h3C00};
  localparam logic [63:0] DTIE = {16'h3C00, 16'h4400, 16'h3C00, 16'h4400};
  localparam logic [63:0] DNAN = {16'h4200, 16'hBC00, 16'h4000, 16'h7E00};
  localparam logic [63:0] DZ   = {16'h4400, 16'h4400, 16'h8000, 16'h0000};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; ivalid = 1'b0; isel = '0; imode = 1'b0; idata = '0;
    istart = 1'b0; ilast = 1'b0; oready = 1'b1;
    #12;
    check("rst_ovalid", ovalid, 32'd0);
    check("rst_odata",  odata,  32'd0);
    check("rst_oempty", oempty, 32'd0);
    check("rst_ostart", ostart, 32'd0);
    check("rst_olast",  olast,  32'd0);
    check("rst_oidx",   oidx,   32'd0);
    check("rst_iready", iready, 32'd1);
    @(negedge aclk);
    areset = 1'b0;

    // Basic min, then max, then alternating back-to-back beats.
    send(4'hF, 1'b0, D1, 1'b0, 1'b0, 1'b0);
    drain();
    send(4'hF, 1'b1, D1, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 6; b++) send(4'hF, 1'(b % 2), D1, 1'b0, 1'b0, 1'b0);
    drain();

    // Ties, empty masks, NaN and signed zeros.
    send(4'hF, 1'b0, DTIE, 1'b0, 1'b0, 1'b0);
    send(4'hF, 1'b1, DTIE, 1'b0, 1'b0, 1'b0);
    send(4'h0, 1'b0, D1,   1'b0, 1'b0, 1'b0);
    send(4'h0, 1'b1, D1,   1'b0, 1'b0, 1'b0);
    send(4'hF, 1'b0, DNAN, 1'b0, 1'b0, 1'b0);
    send(4'h1, 1'b0, DNAN, 1'b0, 1'b0, 1'b0);
    send(4'h3, 1'b0, DZ,   1'b0, 1'b0, 1'b0);
    send(4'h3, 1'b1, DZ,   1'b0, 1'b0, 1'b0);
    send(4'hA, 1'b1, D1,   1'b0, 1'b0, 1'b0);
    drain();

    // Random beats under random backpressure.
    chk_lat = 1'b0;
    for (int b = 0; b < 30; b++) begin
      send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rand_data(), 1'b0, 1'b0, 1'b1);
      if ($urandom_range(0, 3) == 0) idle(1'b1);
    end
    drain();

    // Six-beat frame with gaps and random stalls.
    for (int b = 0; b < 6; b++) begin
      repeat ($urandom_range(0, 2)) idle(1'b1);
      send(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), rand_data(),
           1'(b == 0), 1'(b == 5), 1'b1);
    end
    drain();

    // Asynchronous reset mid-frame, between clock edges.
    chk_lat = 1'b1;
    send(4'hF, 1'b0, D1, 1'b1, 1'b0, 1'b0);
    send(4'hF, 1'b1, D1, 1'b0, 1'b0, 1'b0);
    ivalid = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    check("arst_ovalid", ovalid, 32'd0);
    check("arst_ostart", ostart, 32'd0);
    check("arst_iready", iready, 32'd1);
    sb.delete();
    @(negedge aclk);
    areset = 1'b0;
    send(4'hF, 1'b1, D1,   1'b1, 1'b0, 1'b0);
    send(4'hF, 1'b0, DTIE, 1'b0, 1'b0, 1'b0);
    send(4'hF, 1'b0, DNAN, 1'b0, 1'b1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
